// File: rtl/traffic_pkg.sv
// Shared definitions for the side-road detector and the traffic light controller:
// detector FSM states, light encodings and the vehicle-count width.
package traffic_pkg;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        SERVE = 2'd2,
        CLEAR = 2'd3
    } det_state_t;

    localparam logic [2:0] GREEN  = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] RED    = 3'b001;

    localparam logic [CNT_W-1:0] CNT_ZERO = 4'd0;
    localparam logic [CNT_W-1:0] CNT_ONE  = 4'd1;

    // An arrival and a departure in the same cycle cancel; arrivals at max_cnt are dropped.
    function automatic logic [CNT_W-1:0] count_next(
        input logic [CNT_W-1:0] cur,
        input logic             arrival,
        input logic             tick,
        input logic [CNT_W-1:0] max_cnt
    );
        logic [CNT_W-1:0] nxt;
        nxt = cur;
        if (arrival && !tick) begin
            if (cur == max_cnt) begin
                nxt = cur;
            end else begin
                nxt = cur + CNT_ONE;
            end
        end else if (tick && !arrival) begin
            nxt = cur - CNT_ONE;
        end else begin
            nxt = cur;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/loop_debounce.sv
// Two-flop synchroniser and stability counter for the raw inductive-loop sensor.
// loop_db only follows the synchronised level after DEBOUNCE_CYC consecutive differing cycles.
module loop_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic loop_raw,
    output logic loop_db
);

    localparam logic [3:0] DEB_LAST_C = 4'(DEBOUNCE_CYC - 32'd1);

    logic       sync1_r;
    logic       sync2_r;
    logic       db_r;
    logic [3:0] cnt_r;
    logic       db_nxt_s;
    logic [3:0] cnt_nxt_s;

    // Debounce next-state: count mismatching cycles, commit the new level on the last one.
    always_comb begin
        db_nxt_s  = db_r;
        cnt_nxt_s = 4'd0;
        if (sync2_r != db_r) begin
            if (cnt_r == DEB_LAST_C) begin
                db_nxt_s  = sync2_r;
                cnt_nxt_s = 4'd0;
            end else begin
                db_nxt_s  = db_r;
                cnt_nxt_s = cnt_r + 4'd1;
            end
        end else begin
            db_nxt_s  = db_r;
            cnt_nxt_s = 4'd0;
        end
    end

    // Synchroniser, debounced level and stability counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            db_r    <= 1'b0;
            cnt_r   <= 4'd0;
        end else begin
            sync1_r <= loop_raw;
            sync2_r <= sync1_r;
            db_r    <= db_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    assign loop_db = db_r;

endmodule

// File: rtl/side_road_vehicle_detector.sv
// Side-road vehicle detector: debounced loop arrivals feed a saturating queue count
// that is drained one vehicle per DRAIN_CYC cycles of side-road green.
module side_road_vehicle_detector
    import traffic_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 4,
    parameter int unsigned DRAIN_CYC    = 3,
    parameter int unsigned QUEUE_MAX    = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             loop_raw,
    input  logic             fg,
    output logic             s,
    output logic [CNT_W-1:0] veh_cnt,
    output logic             ovf,
    output logic [1:0]       state
);

    localparam logic [5:0]       DRAIN_LAST_C = 6'(DRAIN_CYC - 32'd1);
    localparam logic [CNT_W-1:0] QMAX_C       = 4'(QUEUE_MAX);

    logic             loop_db_s;
    logic             db_d_r;
    logic             arrival_s;
    logic             run_s;
    logic             tick_s;
    logic [5:0]       tmr_r;
    logic [5:0]       tmr_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             ovf_r;
    logic             ovf_nxt_s;
    logic             s_r;
    det_state_t       state_r;
    det_state_t       state_nxt_s;

    loop_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_loop_debounce (
        .clk      (clk),
        .rst      (rst),
        .loop_raw (loop_raw),
        .loop_db  (loop_db_s)
    );

    assign arrival_s = loop_db_s & ~db_d_r;

    // Drain timer: only accumulates green time while serving, wraps on each departure.
    always_comb begin
        run_s     = (state_r == SERVE) && fg;
        tick_s    = run_s && (tmr_r == DRAIN_LAST_C) && (cnt_r != CNT_ZERO);
        tmr_nxt_s = 6'd0;
        if (run_s) begin
            if (tmr_r == DRAIN_LAST_C) begin
                tmr_nxt_s = 6'd0;
            end else begin
                tmr_nxt_s = tmr_r + 6'd1;
            end
        end else begin
            tmr_nxt_s = 6'd0;
        end
    end

    // Queue count and sticky overflow next-state.
    always_comb begin
        cnt_nxt_s = count_next(cnt_r, arrival_s, tick_s, QMAX_C);
        ovf_nxt_s = ovf_r;
        if (cnt_nxt_s == CNT_ZERO) begin
            ovf_nxt_s = 1'b0;
        end else if (arrival_s && !tick_s && (cnt_r == QMAX_C)) begin
            ovf_nxt_s = 1'b1;
        end else begin
            ovf_nxt_s = ovf_r;
        end
    end

    // FSM next-state; fg is ignored while idle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (cnt_nxt_s != CNT_ZERO) begin
                    state_nxt_s = REQ;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REQ: begin
                if (fg && (cnt_r != CNT_ZERO)) begin
                    state_nxt_s = SERVE;
                end else if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = REQ;
                end
            end
            SERVE: begin
                if (!fg) begin
                    if (cnt_nxt_s != CNT_ZERO) begin
                        state_nxt_s = REQ;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else if (cnt_nxt_s == CNT_ZERO) begin
                    state_nxt_s = CLEAR;
                end else begin
                    state_nxt_s = SERVE;
                end
            end
            CLEAR: begin
                if (!fg) begin
                    state_nxt_s = IDLE;
                end else if (arrival_s) begin
                    state_nxt_s = SERVE;
                end else begin
                    state_nxt_s = CLEAR;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, count, request and timer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_d_r  <= 1'b0;
            tmr_r   <= 6'd0;
            cnt_r   <= CNT_ZERO;
            ovf_r   <= 1'b0;
            s_r     <= 1'b0;
            state_r <= IDLE;
        end else begin
            db_d_r  <= loop_db_s;
            tmr_r   <= tmr_nxt_s;
            cnt_r   <= cnt_nxt_s;
            ovf_r   <= ovf_nxt_s;
            s_r     <= (cnt_nxt_s != CNT_ZERO);
            state_r <= state_nxt_s;
        end
    end

    assign s       = s_r;
    assign veh_cnt = cnt_r;
    assign ovf     = ovf_r;
    assign state   = state_r;

endmodule

// File: tb/tb_side_road_vehicle_detector.sv
// Directed plus randomised bench for side_road_vehicle_detector against a queue/window based reference model.
module tb_side_road_vehicle_detector;

    localparam int DEB   = 4;
    localparam int DRAIN = 3;
    localparam int QMAX  = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       loop_raw = 1'b0;
    logic       fg = 1'b0;
    logic       s;
    logic [3:0] veh_cnt;
    logic       ovf;
    logic [1:0] state;

    int vectors = 0;
    int miscompares = 0;

    // reference model
    int m_sync1, m_sync2, m_db, m_db_prev;
    int m_cnt, m_ovf, m_state, m_timer;
    int m_hist[$];

    side_road_vehicle_detector #(
        .DEBOUNCE_CYC (DEB),
        .DRAIN_CYC    (DRAIN),
        .QUEUE_MAX    (QMAX)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .loop_raw (loop_raw),
        .fg       (fg),
        .s        (s),
        .veh_cnt  (veh_cnt),
        .ovf      (ovf),
        .state    (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sync1 = 0; m_sync2 = 0; m_db = 0; m_db_prev = 0;
        m_cnt = 0; m_ovf = 0; m_state = 0; m_timer = 0;
        m_hist.delete();
    endtask

    // One rising edge of the reference model, using the inputs present at that edge.
    task automatic model_edge();
        int arr, tick, nc, ns, old_db, diff;
        arr  = (m_db == 1 && m_db_prev == 0);
        tick = (m_state == 2 && fg === 1'b1 && m_timer == DRAIN - 1);
        nc = m_cnt;
        if (arr && !tick) begin
            if (m_cnt == QMAX) m_ovf = 1;
            else nc = m_cnt + 1;
        end else if (tick && !arr) begin
            nc = m_cnt - 1;
        end
        if (nc == 0) m_ovf = 0;
        ns = m_state;
        case (m_state)
            0: ns = (nc != 0) ? 1 : 0;
            1: ns = (fg === 1'b1 && m_cnt != 0) ? 2 : 1;
            2: if (fg !== 1'b1) ns = (nc != 0) ? 1 : 0;
               else ns = (nc == 0) ? 3 : 2;
            default: if (fg !== 1'b1) ns = 0;
                     else if (arr) ns = 2;
                     else ns = 3;
        endcase
        m_timer = (m_state == 2 && fg === 1'b1) ? (tick ? 0 : m_timer + 1) : 0;
        // debounced level flips once the last DEB synchronised samples all disagree with it
        old_db = m_db;
        m_hist.push_back(m_sync2);
        if (m_hist.size() > DEB) void'(m_hist.pop_front());
        diff = 1;
        foreach (m_hist[i]) if (m_hist[i] == m_db) diff = 0;
        if (m_hist.size() == DEB && diff == 1) begin
            m_db = 1 - m_db;
            m_hist.delete();
        end
        m_db_prev = old_db;
        m_sync2 = m_sync1;
        m_sync1 = (loop_raw === 1'b1) ? 1 : 0;
        m_cnt = nc;
        m_state = ns;
    endtask

    task automatic step();
        @(posedge clk);
        if (rst === 1'b1) model_edge();
        else model_reset();
        #1;
        chk("s", {7'd0, s}, 8'((m_cnt != 0) ? 1 : 0));
        chk("veh_cnt", {4'd0, veh_cnt}, 8'(m_cnt));
        chk("ovf", {7'd0, ovf}, 8'(m_ovf));
        chk("state", {6'd0, state}, 8'(m_state));
    endtask

    task automatic arrive();
        loop_raw = 1'b1;
        repeat (DEB + 2) step();
        loop_raw = 1'b0;
        repeat (DEB + 2) step();
    endtask

    initial begin
        int t0, exp_cnt, hold;
        model_reset();
        #2 rst = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        repeat (20) step();
        chk("idle_cnt", {4'd0, veh_cnt}, 8'd0);

        // glitch rejection then a 5-cycle pulse
        loop_raw = 1'b1;
        repeat (3) step();
        loop_raw = 1'b0;
        repeat (10) step();
        chk("glitch_cnt", {4'd0, veh_cnt}, 8'd0);
        loop_raw = 1'b1;
        repeat (5) step();
        loop_raw = 1'b0;
        step();
        chk("lat_edge5_cnt", {4'd0, veh_cnt}, 8'd0);
        step();
        chk("lat_edge6_cnt", {4'd0, veh_cnt}, 8'd1);
        chk("lat_edge6_s", {7'd0, s}, 8'd1);
        repeat (10) step();

        // queue of three drained at one vehicle per DRAIN cycles
        repeat (2) arrive();
        chk("q3_state", {6'd0, state}, 8'd1);
        fg = 1'b1;
        step();
        chk("serve_state", {6'd0, state}, 8'd2);
        for (int k = 1; k <= 3; k++) begin
            repeat (DRAIN) step();
            chk("drain_cnt", {4'd0, veh_cnt}, 8'(3 - k));
        end
        chk("clear_state", {6'd0, state}, 8'd3);
        chk("clear_s", {7'd0, s}, 8'd0);
        fg = 1'b0;
        step();
        chk("back_idle", {6'd0, state}, 8'd0);

        // green withdrawn mid-drain discards the partial time
        repeat (2) arrive();
        fg = 1'b1;
        repeat (2) step();
        fg = 1'b0;
        step();
        chk("drop_cnt", {4'd0, veh_cnt}, 8'd2);
        chk("drop_state", {6'd0, state}, 8'd1);
        fg = 1'b1;
        repeat (3) step();
        chk("regreen_cnt_hold", {4'd0, veh_cnt}, 8'd2);
        step();
        chk("regreen_first_dec", {4'd0, veh_cnt}, 8'd1);
        repeat (DRAIN) step();
        fg = 1'b0;
        step();

        // saturation and overflow clear
        repeat (16) arrive();
        chk("sat_cnt", {4'd0, veh_cnt}, 8'd15);
        chk("sat_ovf", {7'd0, ovf}, 8'd1);
        fg = 1'b1;
        repeat (1 + QMAX * DRAIN) step();
        chk("sat_drained_cnt", {4'd0, veh_cnt}, 8'd0);
        chk("sat_drained_ovf", {7'd0, ovf}, 8'd0);
        fg = 1'b0;
        step();

        // arrival landing on the same cycle as a drain tick
        repeat (5) arrive();
        fg = 1'b1;
        step();
        t0 = (((DRAIN - 1 - (DEB + 2)) % DRAIN) + DRAIN) % DRAIN;
        for (int i = 0; i < DRAIN && m_timer != t0; i++) step();
        loop_raw = 1'b1;
        repeat (DEB + 2) step();
        exp_cnt = m_cnt;
        step();
        chk("simul_cnt", {4'd0, veh_cnt}, 8'(exp_cnt));
        loop_raw = 1'b0;
        step();

        // asynchronous reset while serving
        #3 rst = 1'b0;
        #1;
        model_reset();
        chk("areset_s", {7'd0, s}, 8'd0);
        chk("areset_cnt", {4'd0, veh_cnt}, 8'd0);
        chk("areset_ovf", {7'd0, ovf}, 8'd0);
        chk("areset_state", {6'd0, state}, 8'd0);
        fg = 1'b0;
        repeat (2) step();
        rst = 1'b1;

        // randomised traffic
        hold = 0;
        for (int c = 0; c < 2000; c++) begin
            if (hold == 0) begin
                loop_raw = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 9);
            end else begin
                hold--;
            end
            if ($urandom_range(0, 15) == 0) fg = ~fg;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
